hist_lut_builder: RTL and testbench

//  Reader side of the histogram RAM filled by the histogram calculator. After a finished histogram
//  (hist_rdy=1), it makes two sequential read passes over all 16384 bins. Pass 1 sums the bins.

---
 rtl/hist_lut_builder.sv | 177 +++++++++++++++++
 tb/tb_hist_lut_builder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_lut_builder.sv
// Histogram-to-LUT builder: pass 1 sums all bins, a serial divide forms the scale factor,
// pass 2 accumulates the CDF and writes a normalised equalisation LUT.
module hist_lut_builder #(
  parameter int RD_LAT = 2,
  parameter int OUT_W  = 8,
  parameter int FRAC   = 24,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              lut_start,
  input  logic              hist_rdy,
  output logic              busy,
  output logic              done,
  output logic [31:0]       total_pix,
  output logic [ADDR_W-1:0] hist_ram_addr,
  input  logic [17:0]       hist_ram_dout,
  output logic              lut_we,
  output logic [ADDR_W-1:0] lut_addr,
  output logic [OUT_W-1:0]  lut_din
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [63:0]       OUT_MAX64 = (64'd1 << OUT_W) - 64'd1;
  localparam logic [63:0]       DVD64     = OUT_MAX64 << FRAC;
  localparam logic [31:0]       DVD       = DVD64[31:0];

  typedef enum logic [2:0] {IDLE, SUM, DIV, MAP, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic              issued_all_reg;
  logic [RD_LAT-1:0] vld_pipe_reg, last_pipe_reg;
  logic [31:0]       sum_reg, total_pix_reg;
  logic [31:0]       rem_reg, quo_reg, recip_reg;
  logic [4:0]        div_cnt_reg;
  logic [31:0]       cdf_reg;
  logic              cdf_vld_reg, cdf_last_reg;
  logic [63:0]       prod_reg;
  logic              prod_vld_reg, prod_last_reg;
  logic              lut_we_reg, lut_last_reg;
  logic [OUT_W-1:0]  lut_din_reg;
  logic [ADDR_W-1:0] lut_addr_reg, wcnt_reg;

  logic        issue, rd_vld, rd_last, div_ge;
  logic [32:0] rem_sh;
  logic [31:0] rem_new, quo_new;
  logic [63:0] p_sh;

  // One address per cycle in either pass until the last bin has gone out.
  assign issue   = ((state_reg == SUM) || (state_reg == MAP)) && !issued_all_reg;
  assign rd_vld  = vld_pipe_reg[RD_LAT-1];
  assign rd_last = last_pipe_reg[RD_LAT-1];

  assign rem_sh  = {rem_reg, quo_reg[31]};
  assign div_ge  = rem_sh >= {1'b0, total_pix_reg};
  assign rem_new = div_ge ? 32'(rem_sh - {1'b0, total_pix_reg}) : rem_sh[31:0];
  assign quo_new = {quo_reg[30:0], div_ge};
  assign p_sh    = prod_reg >> FRAC;

  always_ff @(posedge clk) begin
    if (srst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (lut_start && hist_rdy) state_next = SUM;
      SUM:  if (rd_vld && rd_last) state_next = DIV;
      DIV:  if ((total_pix_reg == 32'd0) || (div_cnt_reg == 5'd31)) state_next = MAP;
      MAP:  if (lut_we_reg && lut_last_reg) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      addr_reg       <= '0;
      issued_all_reg <= 1'b0;
      vld_pipe_reg   <= '0;
      last_pipe_reg  <= '0;
      sum_reg        <= '0;
      total_pix_reg  <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      recip_reg      <= '0;
      div_cnt_reg    <= '0;
      cdf_reg        <= '0;
      cdf_vld_reg    <= 1'b0;
      cdf_last_reg   <= 1'b0;
      prod_reg       <= '0;
      prod_vld_reg   <= 1'b0;
      prod_last_reg  <= 1'b0;
      lut_we_reg     <= 1'b0;
      lut_last_reg   <= 1'b0;
      lut_din_reg    <= '0;
      lut_addr_reg   <= '0;
      wcnt_reg       <= '0;
    end else begin
      vld_pipe_reg[0]  <= issue;
      last_pipe_reg[0] <= issue && (addr_reg == ADDR_MAX);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
        last_pipe_reg[i] <= last_pipe_reg[i-1];
      end

      // Counter parks on the last bin instead of wrapping.
      if (issue) begin
        if (addr_reg == ADDR_MAX) issued_all_reg <= 1'b1;
        else                      addr_reg <= addr_reg + ADDR_ONE;
      end

      if ((state_reg == IDLE) && (state_next == SUM)) begin
        addr_reg       <= '0;
        issued_all_reg <= 1'b0;
        sum_reg        <= '0;
      end

      if ((state_reg == SUM) && rd_vld) begin
        sum_reg <= sum_reg + 32'(hist_ram_dout);
        if (rd_last) begin
          total_pix_reg <= sum_reg + 32'(hist_ram_dout);
          rem_reg       <= '0;
          quo_reg       <= DVD;
          div_cnt_reg   <= '0;
        end
      end

      if (state_reg == DIV) begin
        if (total_pix_reg == 32'd0) begin
          recip_reg <= '0;
        end else begin
          rem_reg     <= rem_new;
          quo_reg     <= quo_new;
          div_cnt_reg <= div_cnt_reg + 5'd1;
          if (div_cnt_reg == 5'd31) recip_reg <= quo_new;
        end
        if (state_next == MAP) begin
          addr_reg       <= '0;
          issued_all_reg <= 1'b0;
          cdf_reg        <= '0;
          wcnt_reg       <= '0;
        end
      end

      // MAP pipeline: inclusive CDF, scale multiply, clamp and write.
      cdf_vld_reg  <= (state_reg == MAP) && rd_vld;
      cdf_last_reg <= (state_reg == MAP) && rd_vld && rd_last;
      if ((state_reg == MAP) && rd_vld) cdf_reg <= cdf_reg + 32'(hist_ram_dout);

      prod_vld_reg  <= cdf_vld_reg;
      prod_last_reg <= cdf_last_reg;
      prod_reg      <= 64'(cdf_reg) * 64'(recip_reg);

      lut_we_reg   <= prod_vld_reg;
      lut_last_reg <= prod_vld_reg && prod_last_reg;
      if (prod_vld_reg) begin
        lut_din_reg  <= (p_sh > OUT_MAX64) ? OUT_MAX64[OUT_W-1:0] : p_sh[OUT_W-1:0];
        lut_addr_reg <= wcnt_reg;
        wcnt_reg     <= wcnt_reg + ADDR_ONE;
      end
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign total_pix     = total_pix_reg;
  assign hist_ram_addr = addr_reg;
  assign lut_we        = lut_we_reg;
  assign lut_addr      = lut_addr_reg;
  assign lut_din       = lut_din_reg;

endmodule

// File: tb/tb_hist_lut_builder.sv
// Directed bench: one full-size builder (RD_LAT=2) plus three 1024-bin builders
// with RD_LAT=1,2,3 sharing a histogram image; each has its own RAM model and LUT capture.
module tb_hist_lut_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, hist_rdy, start_b, start_s, clr;

  logic        b_busy, b_done, b_we;
  logic [31:0] b_total;
  logic [13:0] b_addr, b_waddr;
  logic [17:0] b_dout, b_d1, b_d2;
  logic [7:0]  b_din;

  logic        s_busy [3];
  logic        s_done [3];
  logic        s_we   [3];
  logic [31:0] s_total[3];
  logic [9:0]  s_addr [3];
  logic [9:0]  s_waddr[3];
  logic [17:0] s_dout [3];
  logic [7:0]  s_din  [3];

  logic [17:0] mem_b [16384];
  logic [17:0] mem_s [1024];

  // Index 0..2: small builders, index 3: full-size builder.
  logic [13:0] m_addr [4];
  logic [13:0] m_waddr[4];
  logic        m_we   [4];
  logic        m_done [4];
  logic [7:0]  m_din  [4];

  hist_lut_builder #(.RD_LAT(2)) u_big (
    .clk(clk), .srst(srst), .lut_start(start_b), .hist_rdy(hist_rdy),
    .busy(b_busy), .done(b_done), .total_pix(b_total),
    .hist_ram_addr(b_addr), .hist_ram_dout(b_dout),
    .lut_we(b_we), .lut_addr(b_waddr), .lut_din(b_din)
  );

  always @(posedge clk) begin
    b_d1 <= mem_b[b_addr];
    b_d2 <= b_d1;
  end
  assign b_dout = b_d2;

  assign m_addr[3]  = b_addr;
  assign m_waddr[3] = b_waddr;
  assign m_we[3]    = b_we;
  assign m_done[3]  = b_done;
  assign m_din[3]   = b_din;

  for (genvar gi = 0; gi < 3; gi++) begin : g_small
    logic [17:0] d1, d2, d3;
    always @(posedge clk) begin
      d1 <= mem_s[s_addr[gi]];
      d2 <= d1;
      d3 <= d2;
    end
    assign s_dout[gi] = (gi == 0) ? d1 : ((gi == 1) ? d2 : d3);

    hist_lut_builder #(.RD_LAT(gi + 1), .ADDR_W(10)) u_dut (
      .clk(clk), .srst(srst), .lut_start(start_s), .hist_rdy(hist_rdy),
      .busy(s_busy[gi]), .done(s_done[gi]), .total_pix(s_total[gi]),
      .hist_ram_addr(s_addr[gi]), .hist_ram_dout(s_dout[gi]),
      .lut_we(s_we[gi]), .lut_addr(s_waddr[gi]), .lut_din(s_din[gi])
    );

    assign m_addr[gi]  = {4'b0, s_addr[gi]};
    assign m_waddr[gi] = {4'b0, s_waddr[gi]};
    assign m_we[gi]    = s_we[gi];
    assign m_done[gi]  = s_done[gi];
    assign m_din[gi]   = s_din[gi];
  end

  // Write monitor: captures LUT contents, write count, gaps, ordering and first-write latency.
  int          cyc;
  int          t0       [4];
  int          lat      [4];
  int          we_cnt   [4];
  int          gap_cnt  [4];
  int          order_err[4];
  int          done_cnt [4];
  int          done_bad [4];
  logic [13:0] prev_addr[4];
  logic        prev_we  [4];
  logic [7:0]  lut_m    [4][16384];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      prev_addr[k] <= m_addr[k];
      prev_we[k]   <= m_we[k];
      if ((m_addr[k] == 14'd0) && (prev_addr[k] == ((k == 3) ? 14'h3fff : 14'h03ff)))
        t0[k] <= cyc;
      if (clr) begin
        we_cnt[k]    <= 0;
        gap_cnt[k]   <= 0;
        order_err[k] <= 0;
        done_cnt[k]  <= 0;
        done_bad[k]  <= 0;
        lat[k]       <= -1;
        for (int i = 0; i < 16384; i++) lut_m[k][i] <= 8'hAA;
      end else begin
        if (m_we[k]) begin
          if (we_cnt[k] == 0) lat[k] <= cyc - t0[k];
          if (int'(m_waddr[k]) != we_cnt[k]) order_err[k] <= order_err[k] + 1;
          if (!prev_we[k] && (we_cnt[k] != 0)) gap_cnt[k] <= gap_cnt[k] + 1;
          lut_m[k][m_waddr[k]] <= m_din[k];
          we_cnt[k] <= we_cnt[k] + 1;
        end
        if (m_done[k]) begin
          done_cnt[k] <= done_cnt[k] + 1;
          if (!prev_we[k]) done_bad[k] <= done_bad[k] + 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_small;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; (c < budget) && !ok; c++) begin
      @(negedge clk);
      if (m_done[k]) ok = 1'b1;
    end
  endtask

  task automatic fill_small(input logic [17:0] v);
    for (int i = 0; i < 1024; i++) mem_s[i] = v;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    tick(3);
    n_cmp++;
    if ({b_busy, b_done, b_we, b_addr, b_waddr, b_din, b_total} !== '0) begin
      n_fail++;
      $display("FAIL reset_big: got busy=%b done=%b we=%b addr=%0d waddr=%0d din=%0d total=%0d, required all 0",
               b_busy, b_done, b_we, b_addr, b_waddr, b_din, b_total);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({s_busy[k], s_done[k], s_we[k], s_addr[k], s_waddr[k], s_din[k], s_total[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_small%0d: got busy=%b done=%b we=%b addr=%0d total=%0d, required all 0",
                 k, s_busy[k], s_done[k], s_we[k], s_addr[k], s_total[k]);
      end
    end
    srst = 1'b0;
    tick(1);
    $display("test_reset: reset values checked");
  endtask

  task automatic test_full_ones;
    bit ok;
    int bad;
    for (int i = 0; i < 16384; i++) mem_b[i] = 18'd1;
    clear_mon();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n_cmp++;
    if (b_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_rise: got %b required 1", b_busy); end
    wait_done(3, 40000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL full_done_timeout: got no done required done"); end
    n_cmp++;
    if (b_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_in_done: got %b required 1", b_busy); end
    tick(1);
    n_cmp++;
    if (b_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_fall: got %b required 0", b_busy); end
    tick(4);
    n_cmp++;
    if (b_total !== 32'd16384) begin n_fail++; $display("FAIL full_total: got %0d required 16384", b_total); end
    n_cmp++;
    if (we_cnt[3] != 16384) begin n_fail++; $display("FAIL full_writes: got %0d required 16384", we_cnt[3]); end
    n_cmp++;
    if ((gap_cnt[3] != 0) || (order_err[3] != 0)) begin
      n_fail++; $display("FAIL full_seq: got gaps=%0d order_errs=%0d required 0/0", gap_cnt[3], order_err[3]);
    end
    n_cmp++;
    if (lat[3] != 5) begin n_fail++; $display("FAIL full_latency: got %0d required 5", lat[3]); end
    n_cmp++;
    if ((done_cnt[3] != 1) || (done_bad[3] != 0)) begin
      n_fail++; $display("FAIL full_done: got count=%0d misplaced=%0d required 1/0", done_cnt[3], done_bad[3]);
    end
    n_cmp++;
    if ({lut_m[3][0], lut_m[3][8191], lut_m[3][16383]} !== {8'd0, 8'd127, 8'd255}) begin
      n_fail++; $display("FAIL full_key_bins: got %0d/%0d/%0d required 0/127/255",
                         lut_m[3][0], lut_m[3][8191], lut_m[3][16383]);
    end
    bad = 0;
    for (int i = 0; i < 16384; i++) if (lut_m[3][i] !== 8'(((i + 1) * 255) >> 14)) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL full_table: got %0d wrong entries required 0", bad); end
    $display("test_full_ones: 16384-bin build, %0d writes", we_cnt[3]);
  endtask

  task automatic test_latency_ones;
    bit ok;
    int bad;
    fill_small(18'd1);
    clear_mon();
    pulse_small();
    wait_done(2, 5000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL lat_done_timeout: got no done required done"); end
    tick(5);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (s_total[k] !== 32'd1024) begin n_fail++; $display("FAIL lat_total%0d: got %0d required 1024", k, s_total[k]); end
      n_cmp++;
      if (lat[k] != k + 4) begin n_fail++; $display("FAIL lat_first_write%0d: got %0d required %0d", k, lat[k], k + 4); end
      n_cmp++;
      if ((we_cnt[k] != 1024) || (gap_cnt[k] != 0) || (order_err[k] != 0)) begin
        n_fail++; $display("FAIL lat_stream%0d: got writes=%0d gaps=%0d order_errs=%0d required 1024/0/0",
                           k, we_cnt[k], gap_cnt[k], order_err[k]);
      end
      n_cmp++;
      if ((done_cnt[k] != 1) || (done_bad[k] != 0)) begin
        n_fail++; $display("FAIL lat_done%0d: got count=%0d misplaced=%0d required 1/0", k, done_cnt[k], done_bad[k]);
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lut_m[k][i] !== 8'(((i + 1) * 255) >> 10)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL lat_table%0d: got %0d wrong entries required 0", k, bad); end
    end
    n_cmp++;
    if (lut_m[1][511] !== 8'd127) begin n_fail++; $display("FAIL lat_mid_bin: got %0d required 127", lut_m[1][511]); end
    $display("test_latency_ones: RD_LAT 1/2/3 latencies %0d/%0d/%0d", lat[0], lat[1], lat[2]);
  endtask

  task automatic test_single_bin;
    bit ok;
    int bad;
    fill_small(18'd0);
    mem_s[100] = 18'd131072;
    clear_mon();
    pulse_small();
    wait_done(2, 5000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got no done required done"); end
    tick(5);
    n_cmp++;
    if (s_total[1] !== 32'd131072) begin n_fail++; $display("FAIL single_total: got %0d required 131072", s_total[1]); end
    n_cmp++;
    if ({lut_m[1][99], lut_m[1][100], lut_m[1][1023]} !== {8'd0, 8'd255, 8'd255}) begin
      n_fail++; $display("FAIL single_edge: got %0d/%0d/%0d required 0/255/255",
                         lut_m[1][99], lut_m[1][100], lut_m[1][1023]);
    end
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lut_m[k][i] !== ((i < 100) ? 8'd0 : 8'd255)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL single_table%0d: got %0d wrong entries required 0", k, bad); end
    end
    $display("test_single_bin: step at bin 100");
  endtask

  task automatic test_zero;
    bit ok;
    int bad;
    fill_small(18'd0);
    clear_mon();
    pulse_small();
    wait_done(2, 5000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL zero_done_timeout: got no done required done"); end
    tick(5);
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lut_m[k][i] !== 8'd0) bad++;
      n_cmp++;
      if ((s_total[k] !== 32'd0) || (we_cnt[k] != 1024) || (bad != 0)) begin
        n_fail++; $display("FAIL zero_build%0d: got total=%0d writes=%0d nonzero=%0d required 0/1024/0",
                           k, s_total[k], we_cnt[k], bad);
      end
      n_cmp++;
      if ((done_cnt[k] != 1) || (s_busy[k] !== 1'b0)) begin
        n_fail++; $display("FAIL zero_finish%0d: got done=%0d busy=%b required 1/0", k, done_cnt[k], s_busy[k]);
      end
    end
    $display("test_zero: empty histogram, %0d writes", we_cnt[0]);
  endtask

  task automatic test_ignored_start;
    bit ok;
    int bad;
    fill_small(18'd1);
    clear_mon();
    hist_rdy = 1'b0;
    pulse_small();
    tick(10);
    n_cmp++;
    if ({s_busy[0], s_busy[1], s_busy[2]} !== 3'b000 || we_cnt[0] != 0) begin
      n_fail++; $display("FAIL ign_not_ready: got busy=%b%b%b writes=%0d required 000/0",
                         s_busy[0], s_busy[1], s_busy[2], we_cnt[0]);
    end
    hist_rdy = 1'b1;
    pulse_small();
    tick(300);
    pulse_small();
    hist_rdy = 1'b0;
    tick(50);
    hist_rdy = 1'b1;
    n_cmp++;
    if ({s_busy[0], s_busy[1], s_busy[2]} !== 3'b111) begin
      n_fail++; $display("FAIL ign_busy_hold: got %b%b%b required 111", s_busy[0], s_busy[1], s_busy[2]);
    end
    ok = 1'b0;
    for (int c = 0; (c < 5000) && !ok; c++) begin
      @(negedge clk);
      if (s_we[2]) ok = 1'b1;
    end
    pulse_small();
    wait_done(2, 5000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ign_done_timeout: got no done required done"); end
    tick(30);
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lut_m[k][i] !== 8'(((i + 1) * 255) >> 10)) bad++;
      n_cmp++;
      if ((we_cnt[k] != 1024) || (done_cnt[k] != 1) || (s_busy[k] !== 1'b0) || (bad != 0)) begin
        n_fail++; $display("FAIL ign_result%0d: got writes=%0d done=%0d busy=%b bad=%0d required 1024/1/0/0",
                           k, we_cnt[k], done_cnt[k], s_busy[k], bad);
      end
    end
    $display("test_ignored_start: stray starts and hist_rdy drop ignored");
  endtask

  task automatic test_abort;
    bit ok;
    int bad;
    fill_small(18'd1);
    clear_mon();
    pulse_small();
    ok = 1'b0;
    for (int c = 0; (c < 5000) && !ok; c++) begin
      @(negedge clk);
      if (s_we[1] && (s_waddr[1] == 10'd500)) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL abort_reach_bin: got bin 500 not reached required reached"); end
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ((s_we[k] !== 1'b0) || (s_busy[k] !== 1'b0)) begin
        n_fail++; $display("FAIL abort_stop%0d: got we=%b busy=%b required 0/0", k, s_we[k], s_busy[k]);
      end
    end
    tick(2000);
    n_cmp++;
    if ((done_cnt[0] + done_cnt[1] + done_cnt[2]) != 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt[0] + done_cnt[1] + done_cnt[2]);
    end
    clear_mon();
    pulse_small();
    wait_done(2, 5000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout: got no done required done"); end
    tick(5);
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) if (lut_m[k][i] !== 8'(((i + 1) * 255) >> 10)) bad++;
      n_cmp++;
      if ((we_cnt[k] != 1024) || (done_cnt[k] != 1) || (bad != 0)) begin
        n_fail++; $display("FAIL abort_restart%0d: got writes=%0d done=%0d bad=%0d required 1024/1/0",
                           k, we_cnt[k], done_cnt[k], bad);
      end
    end
    $display("test_abort: reset at bin 500, rebuild complete");
  endtask

  initial begin
    srst     = 1'b1;
    hist_rdy = 1'b1;
    start_b  = 1'b0;
    start_s  = 1'b0;
    clr      = 1'b0;
    for (int i = 0; i < 16384; i++) mem_b[i] = 18'd0;
    for (int i = 0; i < 1024; i++) mem_s[i] = 18'd0;
    tick(2);
    test_reset();
    test_full_ones();
    test_latency_ones();
    test_single_bin();
    test_zero();
    test_ignored_start();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
